// File: rtl/params.sv
// Environment-wide geometry and word widths shared by the environment and its
// maintenance engines. Modules take these as parameter defaults so a small
// grid can be elaborated without editing this file.
package params_pkg;
   localparam int X_bits      = 8;
   localparam int Y_bits      = 8;
   localparam int SIGNAL_bits = 8;
   localparam int PIXELS_X    = 160;
   localparam int PIXELS_Y    = 120;
endpackage

// File: rtl/env_decay_sweeper.sv
// env_decay_sweeper: walks every environment cell in X-major order and writes
// back its pheromone signal reduced by DECAY_STEP (saturating at 0), leaving
// the sugar bit untouched. A sweep starts on a start pulse or automatically
// SWEEP_PERIOD idle cycles after the previous one (0 disables auto-start).
// An ant-side writer owning the write port (hold=1) stalls the cursor.
//
// Optional feature macro: ENV_SWEEP_SKIP_ZERO_EN -- when defined, cells whose
// signal is already 0 are visited but not written.
//
// Handshake: write_flag is a single-cycle write strobe; the environment
// commits {write_X, write_Y, write_signal, write_sugar} on the rising edge
// where write_flag=1. There is no back-pressure other than hold, which both
// suppresses write_flag and freezes the cursor for that cycle.
module env_decay_sweeper #(
   parameter int X_bits                        = params_pkg::X_bits,
   parameter int Y_bits                        = params_pkg::Y_bits,
   parameter int SIGNAL_bits                   = params_pkg::SIGNAL_bits,
   parameter int PIXELS_X                      = params_pkg::PIXELS_X,
   parameter int PIXELS_Y                      = params_pkg::PIXELS_Y,
   parameter logic [SIGNAL_bits-1:0] DECAY_STEP = SIGNAL_bits'(1),
   parameter int unsigned SWEEP_PERIOD         = 1024
) (
   input  logic                   newLocClock,
   input  logic                   RESET_SIM,
   input  logic                   start,
   input  logic                   hold,
   output logic [X_bits-1:0]      lookup_X,
   output logic [Y_bits-1:0]      lookup_Y,
   input  logic [SIGNAL_bits-1:0] lookup_signal,
   input  logic                   lookup_sugar,
   output logic [X_bits-1:0]      write_X,
   output logic [Y_bits-1:0]      write_Y,
   output logic [SIGNAL_bits-1:0] write_signal,
   output logic                   write_sugar,
   output logic                   write_flag,
   output logic                   busy,
   output logic                   sweep_done,
   output logic [1:0]             state_dbg
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [X_bits-1:0] LAST_X      = X_bits'(PIXELS_X - 1);
   localparam logic [Y_bits-1:0] LAST_Y      = Y_bits'(PIXELS_Y - 1);
   localparam bit                AUTO_EN     = (SWEEP_PERIOD != 0);
   localparam logic [31:0]       PERIOD_LAST = AUTO_EN ? 32'(SWEEP_PERIOD - 1) : 32'd0;

   state_t                 state;
   logic [X_bits-1:0]      cur_x;
   logic [Y_bits-1:0]      cur_y;
   logic [31:0]            period_cnt;
   logic                   auto_start;
   logic                   last_x;
   logic                   last_cell;
   logic                   skip_cell;
   logic [SIGNAL_bits-1:0] decayed;

   assign auto_start = AUTO_EN && (period_cnt == PERIOD_LAST);
   assign last_x     = (cur_x == LAST_X);
   assign last_cell  = last_x && (cur_y == LAST_Y);
   assign state_dbg  = state;

   // Addresses always follow the cursor; outside a sweep that is (0,0).
   assign lookup_X = cur_x;
   assign lookup_Y = cur_y;
   assign write_X  = cur_x;
   assign write_Y  = cur_y;

`ifdef ENV_SWEEP_SKIP_ZERO_EN
   // A cell already at 0 would be rewritten with 0, so leave the port free.
   assign skip_cell = (lookup_signal == '0);
`else
   assign skip_cell = 1'b0;
`endif

   // Saturating decay of the value read back for the current cell.
   always_comb begin
      decayed = '0;
      if (lookup_signal >= DECAY_STEP)
         decayed = lookup_signal - DECAY_STEP;
   end

   // Write-port drive: only active while sweeping, quiet zeros otherwise.
   always_comb begin
      write_flag   = 1'b0;
      write_signal = '0;
      write_sugar  = 1'b0;
      if (state == SWEEP) begin
         write_flag   = !hold && !skip_cell;
         write_signal = decayed;
         write_sugar  = lookup_sugar;
      end
   end

   // Sweep controller: state, cursor, idle-period counter and status flags.
   always_ff @(posedge newLocClock) begin
      if (RESET_SIM) begin
         state      <= IDLE;
         cur_x      <= '0;
         cur_y      <= '0;
         period_cnt <= '0;
         busy       <= 1'b0;
         sweep_done <= 1'b0;
      end else begin
         sweep_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start || auto_start) begin
                  state <= SWEEP;
                  busy  <= 1'b1;
                  cur_x <= '0;
                  cur_y <= '0;
               end else begin
                  period_cnt <= period_cnt + 32'd1;
               end
            end
            SWEEP: begin
               // Skipped cells still advance; only hold freezes the cursor.
               if (!hold) begin
                  if (last_cell) begin
                     state      <= DONE;
                     busy       <= 1'b0;
                     sweep_done <= 1'b1;
                     cur_x      <= '0;
                     cur_y      <= '0;
                  end else if (last_x) begin
                     cur_x <= '0;
                     cur_y <= cur_y + 1'b1;
                  end else begin
                     cur_x <= cur_x + 1'b1;
                  end
               end
            end
            DONE: begin
               state      <= IDLE;
               period_cnt <= '0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_env_decay_sweeper.sv
// Bench for env_decay_sweeper on a 4x3 grid with DECAY_STEP=2. Instance dut
// runs with auto-start disabled against an environment memory model; instance
// dut_p runs with SWEEP_PERIOD=8 to time the auto-start.
`timescale 1ns/1ps
module tb_env_decay_sweeper;
   import params_pkg::*;

   localparam int PX    = 4;
   localparam int PY    = 3;
   localparam int NCELL = PX * PY;
   localparam int STEP  = 2;
   localparam int W     = X_bits + Y_bits + SIGNAL_bits + 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst   = 1'b1;
   logic rst_b = 1'b1;
   logic start = 1'b0;
   logic hold  = 1'b0;

   // ---------------- dut (no auto-start) ----------------
   logic [X_bits-1:0]      lookup_x, write_x;
   logic [Y_bits-1:0]      lookup_y, write_y;
   logic [SIGNAL_bits-1:0] lookup_signal, write_signal;
   logic                   lookup_sugar, write_sugar, write_flag, busy, sweep_done;
   logic [1:0]             state_dbg;

   env_decay_sweeper #(
      .PIXELS_X(PX), .PIXELS_Y(PY),
      .DECAY_STEP(SIGNAL_bits'(STEP)), .SWEEP_PERIOD(0)
   ) dut (
      .newLocClock(clk), .RESET_SIM(rst), .start(start), .hold(hold),
      .lookup_X(lookup_x), .lookup_Y(lookup_y),
      .lookup_signal(lookup_signal), .lookup_sugar(lookup_sugar),
      .write_X(write_x), .write_Y(write_y),
      .write_signal(write_signal), .write_sugar(write_sugar),
      .write_flag(write_flag), .busy(busy), .sweep_done(sweep_done),
      .state_dbg(state_dbg)
   );

   // ---------------- dut_p (auto-start every 8 idle cycles) ----------------
   logic [X_bits-1:0]      lookup_x_b, write_x_b;
   logic [Y_bits-1:0]      lookup_y_b, write_y_b;
   logic [SIGNAL_bits-1:0] write_signal_b;
   logic [SIGNAL_bits-1:0] lookup_signal_b = SIGNAL_bits'(9);
   logic                   lookup_sugar_b = 1'b0;
   logic                   start_b = 1'b0;
   logic                   hold_b  = 1'b0;
   logic                   write_sugar_b, write_flag_b, busy_b, sweep_done_b;
   logic [1:0]             state_dbg_b;

   env_decay_sweeper #(
      .PIXELS_X(PX), .PIXELS_Y(PY),
      .DECAY_STEP(SIGNAL_bits'(STEP)), .SWEEP_PERIOD(8)
   ) dut_p (
      .newLocClock(clk), .RESET_SIM(rst_b), .start(start_b), .hold(hold_b),
      .lookup_X(lookup_x_b), .lookup_Y(lookup_y_b),
      .lookup_signal(lookup_signal_b), .lookup_sugar(lookup_sugar_b),
      .write_X(write_x_b), .write_Y(write_y_b),
      .write_signal(write_signal_b), .write_sugar(write_sugar_b),
      .write_flag(write_flag_b), .busy(busy_b), .sweep_done(sweep_done_b),
      .state_dbg(state_dbg_b)
   );

   // ---------------- environment memory model ----------------
   logic [SIGNAL_bits-1:0] sig_a[NCELL];
   logic                   sug_a[NCELL];
   logic [SIGNAL_bits-1:0] load_sig[NCELL];
   logic                   load_sug[NCELL];
   logic                   load_en = 1'b0;
   int                     lk_idx, wr_idx;

   always_comb begin
      lk_idx        = int'(lookup_y) * PX + int'(lookup_x);
      wr_idx        = int'(write_y) * PX + int'(write_x);
      lookup_signal = '0;
      lookup_sugar  = 1'b0;
      if (lk_idx < NCELL) begin
         lookup_signal = sig_a[lk_idx];
         lookup_sugar  = sug_a[lk_idx];
      end
   end

   always @(posedge clk) begin
      if (load_en) begin
         for (int i = 0; i < NCELL; i++) begin
            sig_a[i] <= load_sig[i];
            sug_a[i] <= load_sug[i];
         end
      end else if (write_flag && wr_idx < NCELL) begin
         sig_a[wr_idx] <= write_signal;
         sug_a[wr_idx] <= write_sugar;
      end
   end

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int checks = 0;
   int errors = 0;
   int wr_seen = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] pack_wr(input int x, input int y, input int s, input logic g);
      return {X_bits'(x), Y_bits'(y), SIGNAL_bits'(s), g};
   endfunction

   // Expected writes for cells first..last from the current model contents.
   task automatic push_sweep(input int first, input int last);
      int s;
      int d;
      for (int i = first; i <= last; i++) begin
         s = int'(sig_a[i]);
         d = (s >= STEP) ? s - STEP : 0;
`ifdef ENV_SWEEP_SKIP_ZERO_EN
         if (s != 0)
            exp_q.push_back(pack_wr(i % PX, i / PX, d, sug_a[i]));
`else
         exp_q.push_back(pack_wr(i % PX, i / PX, d, sug_a[i]));
`endif
      end
   endtask

   // Called at a negedge: compare any write strobe with the queue head.
   task automatic observe();
      logic [W-1:0] e;
      if (write_flag) begin
         if (exp_q.size() == 0) begin
            check("spurious_write", 32'(write_flag), 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("write", 32'(pack_wr(int'(write_x), int'(write_y), int'(write_signal), write_sugar)),
                  32'(e));
            wr_seen++;
         end
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_env();
      @(posedge clk); #1 load_en = 1'b1;
      @(posedge clk); #1 load_en = 1'b0;
   endtask

   // Pulse start, then run until sweep_done (bounded). k counts sweep cycles
   // from 1 (cursor at cell 0); hold covers cycles hold_at..hold_at+len-1 and
   // a stray start is driven on cycle start_at.
   task automatic do_sweep(input int hold_at, input int hold_len, input int start_at,
                           output int done_n);
      done_n = 0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         hold  = (k >= hold_at) && (k < hold_at + hold_len);
         start = (k == start_at);
         @(negedge clk);
         observe();
         if (k == 1) check("busy_in_sweep", 32'(busy), 32'd1);
         if (hold) begin
            check("hold_no_write", 32'(write_flag), 32'd0);
            check("hold_x", 32'(lookup_x), 32'((hold_at - 1) % PX));
            check("hold_y", 32'(lookup_y), 32'((hold_at - 1) / PX));
         end
         if (sweep_done) begin
            done_n = k;
            check("busy_at_done", 32'(busy), 32'd0);
            break;
         end
         @(posedge clk); #1;
      end
      hold  = 1'b0;
      start = 1'b0;
      @(posedge clk); #1;
      @(negedge clk);
      check("done_is_pulse", 32'(sweep_done), 32'd0);
      check("idle_after_done", 32'(state_dbg), 32'd0);
      check("busy_after_done", 32'(busy), 32'd0);
   endtask

   // ---------------- main sequence ----------------
   int done_n;
   int gap;
   int len;
   logic saw_done;
   logic saw_wr;

   initial begin
      for (int i = 0; i < NCELL; i++) begin
         load_sig[i] = '0;
         load_sug[i] = 1'b0;
      end
      load_env();

      // Reset state.
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(sweep_done), 32'd0);
      check("rst_wflag", 32'(write_flag), 32'd0);
      check("rst_x", 32'(lookup_x), 32'd0);
      check("rst_y", 32'(lookup_y), 32'd0);
      check("rst_state", 32'(state_dbg), 32'd0);
      check("rst_wsig", 32'(write_signal), 32'd0);
      @(posedge clk); #1 rst = 1'b0;

      // Scenario 1: uniform signal 5 -> twelve writes of 3; stray start ignored.
      for (int i = 0; i < NCELL; i++) begin
         load_sig[i] = SIGNAL_bits'(5);
         load_sug[i] = 1'b0;
      end
      load_env();
      wr_seen = 0;
      push_sweep(0, NCELL - 1);
      do_sweep(0, 0, 5, done_n);
      check("s1_done_cycle", 32'(done_n), 32'd13);
      check("s1_writes", 32'(wr_seen), 32'd12);
      check("s1_q_drained", 32'(exp_q.size()), 32'd0);
      saw_done = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         saw_done = saw_done | busy | sweep_done;
      end
      check("s1_start_not_queued", 32'(saw_done), 32'd0);
      check("s1_cell_decayed", 32'(sig_a[9]), 32'd3);

      // Scenario 2: random field, cell (1,0)=1 with sugar -> saturates to 0.
      for (int i = 0; i < NCELL; i++) begin
         load_sig[i] = SIGNAL_bits'($urandom_range(3, 255));
         load_sug[i] = 1'($urandom_range(0, 1));
      end
      load_sig[1]  = SIGNAL_bits'(1);
      load_sug[1]  = 1'b1;
      load_sig[4]  = SIGNAL_bits'(2);
      load_sig[10] = SIGNAL_bits'(255);
      load_env();
      wr_seen = 0;
      push_sweep(0, NCELL - 1);
      do_sweep(0, 0, 0, done_n);
      check("s2_done_cycle", 32'(done_n), 32'd13);
      check("s2_sat_signal", 32'(sig_a[1]), 32'd0);
      check("s2_sugar_kept", 32'(sug_a[1]), 32'd1);
      check("s2_exact_step", 32'(sig_a[4]), 32'd0);
      check("s2_max_decay", 32'(sig_a[10]), 32'd253);
      check("s2_q_drained", 32'(exp_q.size()), 32'd0);

      // Scenario 3: hold three cycles at cursor (2,1).
      for (int i = 0; i < NCELL; i++) begin
         load_sig[i] = SIGNAL_bits'(20 + i);
         load_sug[i] = 1'(i & 1);
      end
      load_env();
      wr_seen = 0;
      push_sweep(0, NCELL - 1);
      do_sweep(7, 3, 0, done_n);
      check("s3_done_cycle", 32'(done_n), 32'd16);
      check("s3_writes", 32'(wr_seen), 32'd12);
      check("s3_q_drained", 32'(exp_q.size()), 32'd0);

      // Scenario 4: reset while the cursor sits at (3,1).
      for (int i = 0; i < NCELL; i++) begin
         load_sig[i] = SIGNAL_bits'(6);
         load_sug[i] = 1'b1;
      end
      load_env();
      wr_seen = 0;
      push_sweep(0, 7);
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         rst = (k == 8);
         @(negedge clk);
         observe();
         if (k == 8) begin
            check("s4_pre_x", 32'(lookup_x), 32'd3);
            check("s4_pre_y", 32'(lookup_y), 32'd1);
         end
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("s4_wflag", 32'(write_flag), 32'd0);
      check("s4_busy", 32'(busy), 32'd0);
      check("s4_state", 32'(state_dbg), 32'd0);
      check("s4_x", 32'(lookup_x), 32'd0);
      check("s4_y", 32'(lookup_y), 32'd0);
      @(posedge clk); #1 rst = 1'b0;
      saw_done = 1'b0;
      saw_wr   = 1'b0;
      for (int k = 0; k < 16; k++) begin
         @(negedge clk);
         saw_done = saw_done | sweep_done;
         saw_wr   = saw_wr | write_flag;
      end
      check("s4_no_done", 32'(saw_done), 32'd0);
      check("s4_no_write", 32'(saw_wr), 32'd0);
      check("s4_writes", 32'(wr_seen), 32'd8);
      check("s4_q_drained", 32'(exp_q.size()), 32'd0);
      wr_seen = 0;
      push_sweep(0, NCELL - 1);
      do_sweep(0, 0, 0, done_n);
      check("s4_restart_done", 32'(done_n), 32'd13);
      check("s4_restart_writes", 32'(wr_seen), 32'd12);

      // Start and reset together: reset wins.
      @(posedge clk); #1 begin rst = 1'b1; start = 1'b1; end
      @(posedge clk); #1 begin rst = 1'b0; start = 1'b0; end
      @(negedge clk);
      check("rst_wins_busy", 32'(busy), 32'd0);
      check("rst_wins_state", 32'(state_dbg), 32'd0);

      // Scenario 6: four zero cells.
      for (int i = 0; i < NCELL; i++) begin
         load_sig[i] = SIGNAL_bits'(10);
         load_sug[i] = 1'b0;
      end
      load_sig[0]  = '0;
      load_sig[5]  = '0;
      load_sig[6]  = '0;
      load_sig[11] = '0;
      load_env();
      wr_seen = 0;
      push_sweep(0, NCELL - 1);
      do_sweep(0, 0, 0, done_n);
      check("s6_done_cycle", 32'(done_n), 32'd13);
`ifdef ENV_SWEEP_SKIP_ZERO_EN
      check("s6_writes", 32'(wr_seen), 32'd8);
`else
      check("s6_writes", 32'(wr_seen), 32'd12);
`endif
      check("s6_q_drained", 32'(exp_q.size()), 32'd0);

      // Scenario 5: auto-start after 8 idle cycles, from reset and after done.
      @(posedge clk); #1 rst_b = 1'b1;
      @(posedge clk); #1 rst_b = 1'b0;
      gap = 0;
      for (int n = 0; n < 50; n++) begin
         @(negedge clk);
         if (busy_b) break;
         gap++;
      end
      check("s5_gap_reset", 32'(gap), 32'd8);
      for (int rep = 0; rep < 2; rep++) begin
         len = 1;
         for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (sweep_done_b) break;
            len++;
         end
         check("s5_sweep_len", 32'(len), 32'd12);
         gap = 0;
         for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            if (busy_b) break;
            gap++;
         end
         check("s5_gap_done", 32'(gap), 32'd8);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/env_decay_sweeper.md
ENV_DECAY_SWEEPER -- requirements
Module: env_decay_sweeper

Interface
REQ-001 Parameter DECAY_STEP, default 1: amount subtracted from each cell's signal per sweep; width SIGNAL_bits.
REQ-002 Parameter SWEEP_PERIOD, default 1024: newLocClock cycles from one sweep's end to the next auto-start; 0 disables auto-start.
REQ-003 X_bits, Y_bits, SIGNAL_bits, PIXELS_X, PIXELS_Y shall come from params.sv.
REQ-004 newLocClock  in  1  sole clock; all state updates on rising edge.
REQ-005 RESET_SIM  in  1  synchronous, active-high reset.
REQ-006 start  in  1  one-cycle request to begin a sweep.
REQ-007 hold  in  1  an ant-side writer owns the environment write port this cycle.
REQ-008 lookup_X / lookup_Y  out  X_bits / Y_bits  cell address driven to the environment lookup port.
REQ-009 lookup_signal  in  SIGNAL_bits  combinational signal read back for lookup_X/lookup_Y.
REQ-010 lookup_sugar  in  1  combinational sugar bit read back.
REQ-011 write_X / write_Y  out  X_bits / Y_bits  write address to the environment.
REQ-012 write_signal  out  SIGNAL_bits  decayed signal value.
REQ-013 write_sugar  out  1  sugar value to write back.
REQ-014 write_flag  out  1  write enable, sampled by the environment on the next rising edge.
REQ-015 busy  out  1  high while a sweep is in progress.
REQ-016 sweep_done  out  1  one-cycle pulse after the last cell is written.

Function
REQ-017 FSM states shall be IDLE, SWEEP, and DONE.
REQ-018 IDLE->SWEEP on start=1, or when the period counter reaches SWEEP_PERIOD-1 with SWEEP_PERIOD!=0; cursor loads (0,0).
REQ-019 In SWEEP, lookup_X/Y and write_X/Y shall equal the cursor combinationally.
REQ-020 In SWEEP, write_signal = lookup_signal - DECAY_STEP, saturating at 0.
REQ-021 In SWEEP, write_sugar shall equal lookup_sugar; sugar is never altered.
REQ-022 write_flag = (state==SWEEP) && !hold; when hold=1 the cursor shall not advance.
REQ-023 On each non-held SWEEP cycle, X shall increment; at PIXELS_X-1 it wraps to 0 and Y increments.
REQ-024 A write at cursor (PIXELS_X-1, PIXELS_Y-1) shall transition to DONE; exactly PIXELS_X*PIXELS_Y writes per sweep.
REQ-025 DONE shall last one cycle with sweep_done=1, then go to IDLE and clear the period counter.
REQ-026 The period counter shall count only in IDLE.
REQ-027 start during SWEEP or DONE shall be ignored, not queued.
REQ-028 busy = (state==SWEEP).
REQ-029 Outside SWEEP, write_flag=0, write_signal=0, and write_sugar=0; addresses shall hold the cursor value.
REQ-030 Minimum sweep latency shall be PIXELS_X*PIXELS_Y cycles; each held cycle adds one.

Reset
REQ-031 RESET_SIM=1 at an edge shall force state IDLE, cursor (0,0), period counter 0, busy=0, sweep_done=0, write_flag=0.
REQ-032 A reset mid-sweep shall abandon the sweep; no further write is issued after the reset edge, and no sweep_done pulse occurs.
REQ-033 When start and RESET_SIM are both high, reset shall win.

Configuration
REQ-034 With ENV_SWEEP_SKIP_ZERO_EN defined, a SWEEP cell with lookup_signal==0 shall assert write_flag=0, and the cursor shall still advance unless hold=1.
REQ-035 Without ENV_SWEEP_SKIP_ZERO_EN, every cell shall be written, zero cells included.

Verification
REQ-036 Bench shall use PIXELS_X=4, PIXELS_Y=3, DECAY_STEP=2, and SWEEP_PERIOD=0 with an environment model.
REQ-037 Scenario 1: all cells signal=5, pulse start -> 12 consecutive writes of 3 in X-major order, sweep_done on cycle 13, busy low after.
REQ-038 Scenario 2: cell (1,0)=1, sugar=1 -> written signal 0, sugar 1 (saturation, sugar preserved).
REQ-039 Scenario 3: hold=1 for 3 cycles at cursor (2,1) -> no write_flag for those cycles, cursor stays (2,1), sweep_done delayed 3 cycles.
REQ-040 Scenario 4: RESET_SIM at cursor (3,1) -> next cycle IDLE, write_flag=0, no sweep_done; a following start restarts at (0,0).
REQ-041 Scenario 5: SWEEP_PERIOD=8, no start -> auto-sweep begins 8 cycles after reset, and again 8 cycles after each sweep_done.
REQ-042 Scenario 6: with ENV_SWEEP_SKIP_ZERO_EN defined and 4 zero cells -> 8 writes, sweep still 12 cycles.
